// File: rtl/generic_fifo_sc_prog.sv
`default_nettype none
// ============================================================================
// Module      : generic_fifo_sc_prog
// Description : Single-clock FIFO with runtime-programmable almost-full /
//               almost-empty thresholds, exact fill level and sticky
//               overflow / underflow flags.
// Revision    : 1.0 - initial release
//
// Build option: GENERIC_FIFO_FWFT_EN
//               defined   -> first-word fall-through (dout shows the head word
//                            whenever empty == 0, backed by a one-entry output
//                            register in front of the core storage)
//               undefined -> standard mode (dout updates one cycle after an
//                            accepted read)
//
// Parameters  : dw  data width in bits
//               aw  address width, depth = 2**aw entries
//
// Ports       : clk      clock, rising edge
//               rst      asynchronous active-low reset
//               clr      synchronous clear, wins over we/re, dout held
//               din      write data
//               we / re  write / read request
//               dout     read data
//               full     level == 2**aw
//               empty    standard: level == 0, FWFT: dout not valid
//               af_thr   almost-full threshold  (1..2**aw)
//               ae_thr   almost-empty threshold (0..2**aw-1)
//               afull    level >= af_thr
//               aempty   level <= ae_thr
//               level    entry count 0..2**aw
//               ovf      sticky: write attempted while full
//               udf      sticky: read attempted while empty
// ============================================================================
module generic_fifo_sc_prog #(
    parameter int dw = 8,
    parameter int aw = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [dw-1:0] din,
    input  logic          we,
    input  logic          re,
    output logic [dw-1:0] dout,
    output logic          full,
    output logic          empty,
    input  logic [aw:0]   af_thr,
    input  logic [aw:0]   ae_thr,
    output logic          afull,
    output logic          aempty,
    output logic [aw:0]   level,
    output logic          ovf,
    output logic          udf
);

    localparam int          c_depth_n = 2 ** aw;
    localparam logic [aw:0] c_depth   = {1'b1, {aw{1'b0}}};
    localparam logic [aw:0] c_one     = {{aw{1'b0}}, 1'b1};
    localparam logic [aw:0] c_zero    = '0;

    // Core storage and pointers. Pointers carry one extra bit so that a
    // completely full core is distinguishable from an empty one.
    logic [dw-1:0] r_mem [c_depth_n];
    logic [aw:0]   r_wp;
    logic [aw:0]   r_rp;
    logic          r_ovf;
    logic          r_udf;
    logic [dw-1:0] r_dout;

    logic [aw:0]   w_core_cnt;
    logic [aw:0]   w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_ok;     // write accepted this cycle
    logic          w_rd_ok;     // read accepted this cycle (user view)
    logic          w_core_rd;   // core storage pops its head this cycle

    assign w_core_cnt = r_wp - r_rp;
    assign w_full     = (w_level == c_depth);
    assign w_wr_ok    = we & ~w_full & ~clr;

`ifdef GENERIC_FIFO_FWFT_EN
    // ------------------------------------------------------------------
    // FWFT: the head word lives in an output register. The register is
    // refilled from core storage whenever it is empty or being popped, so
    // a word written into an empty FIFO becomes visible one cycle after
    // its write edge.
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic w_core_empty;

    assign w_core_empty = (r_wp == r_rp);
    assign w_empty      = ~r_out_valid;
    assign w_rd_ok      = re & r_out_valid & ~clr;
    assign w_core_rd    = ~clr & ~w_core_empty & (~r_out_valid | w_rd_ok);
    // The output register counts towards level and full.
    assign w_level      = w_core_cnt + (r_out_valid ? c_one : c_zero);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
        end else if (w_core_rd) begin
            r_out_valid <= 1'b1;
            r_dout      <= r_mem[r_rp[aw-1:0]];
        end else if (w_rd_ok) begin
            r_out_valid <= 1'b0;
        end
    end
`else
    // ------------------------------------------------------------------
    // Standard mode: dout is loaded on an accepted read, one cycle of
    // latency, and holds otherwise.
    // ------------------------------------------------------------------
    assign w_level   = w_core_cnt;
    assign w_empty   = (w_level == c_zero);
    assign w_rd_ok   = re & ~w_empty & ~clr;
    assign w_core_rd = w_rd_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
        end else if (w_rd_ok) begin
            r_dout <= r_mem[r_rp[aw-1:0]];
        end
    end
`endif

    // Storage array carries no reset; its contents are only observable
    // through pointers that are themselves reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wp[aw-1:0]] <= din;
        end
    end

    // Pointers and sticky error flags. Overflow/underflow are judged on
    // the pre-edge flags, so a full FIFO with we & re takes the read but
    // drops the write (and the mirror case for an empty FIFO).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wp <= r_wp + c_one;
            end
            if (w_core_rd) begin
                r_rp <= r_rp + c_one;
            end
            if (we & w_full) begin
                r_ovf <= 1'b1;
            end
            if (re & w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    // Flags follow the registered state with no extra lag.
    assign dout   = r_dout;
    assign full   = w_full;
    assign empty  = w_empty;
    assign level  = w_level;
    assign afull  = (w_level >= af_thr);
    assign aempty = (w_level <= ae_thr);
    assign ovf    = r_ovf;
    assign udf    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_generic_fifo_sc_prog.sv
`default_nettype none
module tb_generic_fifo_sc_prog;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [7:0] din;
    logic       we;
    logic       re;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic [4:0] af_thr;
    logic [4:0] ae_thr;
    logic       afull;
    logic       aempty;
    logic [4:0] level;
    logic       ovf;
    logic       udf;

    initial forever #5 clk = ~clk;

    generic_fifo_sc_prog #(.dw(8), .aw(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .din    (din),
        .we     (we),
        .re     (re),
        .dout   (dout),
        .full   (full),
        .empty  (empty),
        .af_thr (af_thr),
        .ae_thr (ae_thr),
        .afull  (afull),
        .aempty (aempty),
        .level  (level),
        .ovf    (ovf),
        .udf    (udf)
    );

    // Reference model: contents as a queue, each entry tagged with the
    // clock-edge number at which it was written.
    typedef struct {
        logic [7:0] d;
        int         c;
    } ent_t;

    ent_t       m_q[$];
    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         m_udf;
    int         cyc;
    int         n_tests;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The visible head in FWFT mode must have been written on an earlier edge.
    function automatic bit m_empty();
`ifdef GENERIC_FIFO_FWFT_EN
        return (m_q.size() == 0) || (m_q[0].c == cyc);
`else
        return (m_q.size() == 0);
`endif
    endfunction

    task automatic check_flags();
        check("level",  level,  m_q.size());
        check("full",   full,   m_q.size() == DEPTH);
        check("empty",  empty,  m_empty());
        check("afull",  afull,  m_q.size() >= int'(af_thr));
        check("aempty", aempty, m_q.size() <= int'(ae_thr));
        check("ovf",    ovf,    m_ovf);
        check("udf",    udf,    m_udf);
    endtask

    // One clock cycle of stimulus; called at posedge+1.
    task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
        bit   do_w;
        bit   do_r;
        ent_t e;
        we  = w;
        re  = r;
        clr = c;
        din = d;
        do_w = 1'b0;
        do_r = 1'b0;
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            do_r = r && !m_empty();
            do_w = w && (m_q.size() < DEPTH);
            if (w && m_q.size() == DEPTH) m_ovf = 1'b1;
            if (r && m_empty())           m_udf = 1'b1;
        end
        if (do_r) begin
            e = m_q.pop_front();
            exp_q.push_back(e.d);
        end
        if (do_w) begin
            e.d = d;
            e.c = cyc + 1;
            m_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        we  = 1'b0;
        re  = 1'b0;
        clr = 1'b0;
        check_flags();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    initial begin
        bit         pend;
        logic [7:0] e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
`ifdef GENERIC_FIFO_FWFT_EN
            if (rst && re && !empty && !clr) begin
`else
            if (pend) begin
`endif
                if (exp_q.size() == 0) begin
                    check("dout_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e);
                end
            end
            pend = rst && re && !empty && !clr;
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        rst     = 1'b0;
        clr     = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        din     = 8'h00;
        af_thr  = 5'd12;
        ae_thr  = 5'd2;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_ovf",   ovf,   0);
        check("rst_udf",   udf,   0);
        check("rst_dout",  dout,  8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: fill to full, then overflow attempt
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        step(1'b1, 1'b0, 1'b0, 8'hEE);

        // 2: drain in order, then underflow attempt
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // 3: steady state at level 8 with pointer wrap
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));

        // 4: we & re on full, then on empty
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hDD);
        check("full_wr_rd_level", level, 15);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        check("empty_wr_rd_udf", udf, 1);

        // 5: clear with write at level 5 and ovf set, then async reset
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h99);
        check("clr_level", level, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        #2;
        rst = 1'b0;
        #1;
        check("arst_level", level, 0);
        check("arst_empty", empty, 1);
        check("arst_full",  full,  0);
        check("arst_ovf",   ovf,   0);
        check("arst_dout",  dout,  8'h00);
        m_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef GENERIC_FIFO_FWFT_EN
        // 6: fall-through latency
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        check("fwft_empty_at_write", empty, 1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("fwft_dout", dout, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("fwft_empty_after_pop", empty, 1);
`endif

        // Randomized traffic with occasional clear and threshold changes
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                af_thr = 5'($urandom_range(1, 16));
                ae_thr = 5'($urandom_range(0, 15));
            end
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) == 0, 8'($urandom));
        end

        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
